// File: rtl/minterm_sweep.sv
// Sweeps a 4-input minterm index across a,b,c,d and captures the SoP/PoS responses as truth tables.
// Optional SWEEP_EXPECT_EN adds an EXPECT parameter and an exp_err flag comparing both tables to it.
module minterm_sweep #(
  parameter int unsigned SETTLE = 1
`ifdef SWEEP_EXPECT_EN
  , parameter logic [15:0] EXPECT = 16'hD0C4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s1,
  input  logic        s2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_sop,
  output logic [15:0] tt_pos,
  output logic [15:0] mismatch,
  output logic [4:0]  err_cnt
`ifdef SWEEP_EXPECT_EN
  , output logic      exp_err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q;
  logic [3:0] cnt_q;

  assign {a, b, c, d} = idx_q;
  assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == 4'hF) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;

`ifdef SWEEP_EXPECT_EN
  // Tables as they will look after this edge's sample, so DONE entry sees minterm 15.
  logic [15:0] sop_w, pos_w;
  always_comb begin
    sop_w = tt_sop;
    pos_w = tt_pos;
    sop_w[idx_q] = s1;
    pos_w[idx_q] = s2;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) exp_err <= 1'b0;
    else if (state_q == ST_IDLE && start) exp_err <= 1'b0;
    else if (state_q == ST_SAMPLE && idx_q == 4'hF)
      exp_err <= (sop_w != EXPECT) || (pos_w != EXPECT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      tt_sop   <= '0;
      tt_pos   <= '0;
      mismatch <= '0;
      err_cnt  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          idx_q    <= '0;
          cnt_q    <= RELOAD;
          tt_sop   <= '0;
          tt_pos   <= '0;
          mismatch <= '0;
          err_cnt  <= '0;
        end
        ST_SETTLE: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        ST_SAMPLE: begin
          tt_sop[idx_q]   <= s1;
          tt_pos[idx_q]   <= s2;
          mismatch[idx_q] <= s1 ^ s2;
          if ((s1 ^ s2) && err_cnt != 5'd16) err_cnt <= err_cnt + 5'd1;
          if (idx_q != 4'hF) begin
            idx_q <= idx_q + 4'd1;
            cnt_q <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweep.sv
// Scoreboard bench: two sweepers (SETTLE=1 and SETTLE=3) driven by a model truth table with optional per-minterm s2 flips.
module tb_minterm_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance environment: s1 = fn[idx], s2 = fn[idx] ^ flip[idx]
  logic [15:0] fn0 = 16'h0, fl0 = 16'h0, fn1 = 16'h0, fl1 = 16'h0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic a0, b0, c0, d0, busy0, done0, a1, b1, c1, d1, busy1, done1;
  logic [15:0] sop0, pos0, mm0, sop1, pos1, mm1;
  logic [4:0] ec0, ec1;
  logic [3:0] ix0, ix1;
  assign ix0 = {a0, b0, c0, d0};
  assign ix1 = {a1, b1, c1, d1};
  logic s1_0, s2_0, s1_1, s2_1;
  assign s1_0 = fn0[ix0];
  assign s2_0 = fn0[ix0] ^ fl0[ix0];
  assign s1_1 = fn1[ix1];
  assign s2_1 = fn1[ix1] ^ fl1[ix1];
`ifdef SWEEP_EXPECT_EN
  logic xe0, xe1;
`endif

  minterm_sweep #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .s1(s1_0), .s2(s2_0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .tt_sop(sop0), .tt_pos(pos0), .mismatch(mm0), .err_cnt(ec0)
`ifdef SWEEP_EXPECT_EN
    , .exp_err(xe0)
`endif
  );

  minterm_sweep #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s1(s1_1), .s2(s2_1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .tt_sop(sop1), .tt_pos(pos1), .mismatch(mm1), .err_cnt(ec1)
`ifdef SWEEP_EXPECT_EN
    , .exp_err(xe1)
`endif
  );

  typedef struct {
    int          id;
    logic [15:0] sop, pos, mm;
    logic [4:0]  ec;
    logic        xe;
    int          t0, lat;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int t1 = 0, busy_cnt1 = 0;
  bit step_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_done(input int id, input logic [15:0] sop, input logic [15:0] pos,
                            input logic [15:0] mm, input logic [4:0] ec, input logic xe);
    exp_t e;
    if (q.size() == 0) begin
      chk("spurious_done", 32'(id), 32'hFFFF_FFFF);
      return;
    end
    e = q.pop_front();
    chk("done_id", 32'(id), 32'(e.id));
    chk("tt_sop", 32'(sop), 32'(e.sop));
    chk("tt_pos", 32'(pos), 32'(e.pos));
    chk("mismatch", 32'(mm), 32'(e.mm));
    chk("err_cnt", 32'(ec), 32'(e.ec));
    chk("latency", 32'(cyc - e.t0), 32'(e.lat));
`ifdef SWEEP_EXPECT_EN
    chk("exp_err", 32'(xe), 32'(e.xe));
`endif
  endtask

  always @(negedge clk) begin
    logic x0, x1;
`ifdef SWEEP_EXPECT_EN
    x0 = xe0; x1 = xe1;
`else
    x0 = 1'b0; x1 = 1'b0;
`endif
    if (done0) check_done(0, sop0, pos0, mm0, ec0, x0);
    if (done1) check_done(1, sop1, pos1, mm1, ec1, x1);
    if (busy1) busy_cnt1 <= busy_cnt1 + 1;
    if (step_en && busy1) chk("abcd_step", 32'(ix1), 32'(((cyc - t1) / 4) % 16));
  end

  // Drive one accepted start and push the model's expected result.
  task automatic sweep(input int id, input logic [15:0] f, input logic [15:0] fl);
    exp_t e;
    @(negedge clk);
    if (id == 0) begin fn0 = f; fl0 = fl; start0 = 1'b1; end
    else begin fn1 = f; fl1 = fl; start1 = 1'b1; busy_cnt1 = 0; end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    e.id  = id;
    e.sop = f;
    e.pos = f ^ fl;
    e.mm  = fl;
    e.ec  = 5'($countones(fl));
    e.xe  = (f != 16'hD0C4) || ((f ^ fl) != 16'hD0C4);
    e.t0  = cyc;
    e.lat = (id == 0) ? 32 : 64;
    if (id == 1) t1 = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done(input int id, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((id == 0 && done0) || (id == 1 && done1)) return;
    end
    chk("done_timeout", 32'(id), 32'hFFFF_FFFF);
  endtask

  task automatic wait_idx1(input logic [3:0] v, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy1 && ix1 == v) return;
    end
    chk("idx_timeout", 32'(v), 32'hFFFF_FFFF);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut0"}, {ix0, busy0, done0, ec0}, 32'h0);
    chk({tag, "_dut0_tt"}, {sop0, pos0}, 32'h0);
    chk({tag, "_dut0_mm"}, 32'(mm0), 32'h0);
    chk({tag, "_dut1"}, {ix1, busy1, done1, ec1}, 32'h0);
    chk({tag, "_dut1_tt"}, {sop1, pos1}, 32'h0);
    chk({tag, "_dut1_mm"}, 32'(mm1), 32'h0);
`ifdef SWEEP_EXPECT_EN
    chk({tag, "_exp_err"}, {xe0, xe1}, 32'h0);
`endif
  endtask

  initial begin
    logic [15:0] rf, rfl;
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep, then a two-minterm PoS disagreement
    sweep(0, 16'hD0C4, 16'h0000);
    wait_done(0, 40);
    sweep(0, 16'hD0C4, 16'h0600);
    wait_done(0, 40);
    repeat (5) @(negedge clk);
    chk("hold_pos", 32'(pos0), 32'hD6C4);
    chk("hold_mm", 32'(mm0), 32'h0600);

    for (int k = 0; k < 3; k++) begin
      rf  = 16'($urandom);
      rfl = 16'($urandom);
      sweep(0, rf, rfl);
      wait_done(0, 40);
    end
    sweep(0, 16'hFFFF, 16'hFFFF);
    wait_done(0, 40);

    // All-zero function; then a fresh start clears exp_err
    sweep(0, 16'h0000, 16'h0000);
    wait_done(0, 40);
`ifdef SWEEP_EXPECT_EN
    @(negedge clk);
    chk("exp_err_hold", 32'(xe0), 32'h1);
`endif
    sweep(0, 16'hD0C4, 16'h0000);
`ifdef SWEEP_EXPECT_EN
    chk("exp_err_clr", 32'(xe0), 32'h0);
`endif
    wait_done(0, 40);

    // SETTLE=3 stepping and busy width
    step_en = 1'b1;
    sweep(1, 16'hD0C4, 16'h8001);
    wait_done(1, 80);
    chk("busy_cycles", 32'(busy_cnt1), 32'd64);

    // Start while busy is ignored
    sweep(1, 16'h3A5C, 16'h0000);
    wait_idx1(4'd5, 40);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(1, 80);
    chk("busy_cycles_restart", 32'(busy_cnt1), 32'd64);
    repeat (70) @(negedge clk);

    // Asynchronous reset mid-sweep
    sweep(1, 16'hD0C4, 16'h0000);
    wait_idx1(4'd7, 40);
    step_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    step_en = 1'b1;
    sweep(1, 16'hD0C4, 16'h0010);
    chk("restart_idx", 32'(ix1), 32'h0);
    wait_done(1, 80);
    step_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/minterm_sweep.md
MINTERM_SWEEP -- requirements
Module: minterm_sweep

Interface
REQ-001 Parameter SETTLE, default 1: number of cycles each minterm is held on a,b,c,d before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 s1  input  1  SoP result from the evaluated stage.
REQ-006 s2  input  1  PoS result from the evaluated stage.
REQ-007 a, b, c, d  output  1 each  registered stimulus; a is the MSB of the minterm index, d is the LSB.
REQ-008 busy  output  1  high in SETTLE and SAMPLE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 tt_sop  output  16  captured s1 truth table; bit i holds minterm i.
REQ-011 tt_pos  output  16  captured s2 truth table; bit i holds minterm i.
REQ-012 mismatch  output  16  bit i = s1 XOR s2 sampled at minterm i.
REQ-013 err_cnt  output  5  number of set mismatch bits; range 0..16, no wrap.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE; the 4-bit minterm index idx drives {a,b,c,d}.
REQ-015 In IDLE with start=1, the next edge sets idx=0, clears tt_sop, tt_pos, mismatch and err_cnt, loads the settle counter with SETTLE-1, and enters SETTLE.
REQ-016 In SETTLE, if the counter is 0, go to SAMPLE; otherwise decrement the counter. SETTLE therefore lasts exactly SETTLE cycles.
REQ-017 In SAMPLE, for one cycle: tt_sop[idx]<=s1, tt_pos[idx]<=s2, mismatch[idx]<=s1^s2, and err_cnt increments when s1!=s2.
REQ-018 Leaving SAMPLE: if idx==15, go to DONE with idx held; otherwise idx<=idx+1, reload the counter with SETTLE-1, and return to SETTLE.
REQ-019 DONE lasts one cycle with done=1, then returns to IDLE. The results hold until the next accepted start.
REQ-020 Sweep latency: done is high in the cycle beginning 16*(SETTLE+1) edges after the accepting start edge.
REQ-021 start is ignored in SETTLE, SAMPLE and DONE; no restart and no queueing.
REQ-022 s1 and s2 are sampled only in SAMPLE; their values in all other states have no effect.
REQ-023 idx never wraps within a sweep; minterm 15 is the final sample.

Reset
REQ-024 rst_n low immediately forces IDLE; idx, a, b, c, d, busy, done, tt_sop, tt_pos, mismatch, err_cnt and the counter all go to 0, including mid-sweep.
REQ-025 After rst_n rises, the block waits in IDLE for a new start; no partial results are retained.

Configuration
REQ-026 Macro SWEEP_EXPECT_EN: when defined, the block adds parameter EXPECT (16 bits, default 16'hD0C4) and output exp_err (1 bit).
REQ-027 With SWEEP_EXPECT_EN defined, exp_err is cleared on accepted start and on reset, and is set on entry to DONE when tt_sop!=EXPECT or tt_pos!=EXPECT. It holds until the next start.
REQ-028 Without SWEEP_EXPECT_EN, neither EXPECT nor exp_err exists, and all other behaviour is identical.

Verification
REQ-029 SETTLE=1; s1=s2=f(a,b,c,d) with ON-set {2,6,7,12,14,15}; pulse start -> done 32 cycles later, tt_sop=tt_pos=16'hD0C4, mismatch=0, err_cnt=0 (exp_err=0 if enabled).
REQ-030 Same function, but s2 inverted only at minterm 10 (also at 9) -> mismatch=16'h0600, err_cnt=2, tt_pos=16'hD6C4.
REQ-031 SETTLE=3; sweep -> a,b,c,d step 0..15, each value held 4 cycles; done 64 cycles after the start edge; busy high for exactly 64 cycles.
REQ-032 Pulse start again while busy at idx=5 -> no effect: idx continues 6..15 and exactly one done pulse occurs.
REQ-033 Assert rst_n=0 asynchronously at idx=7 -> all outputs 0 within the same cycle; after release and a new start, the sweep restarts at idx=0.
REQ-034 SWEEP_EXPECT_EN defined, s1=s2=0 for all minterms -> tt_sop=0, exp_err=1 at DONE; a fresh start clears exp_err.
